demux: RTL and testbench

Registered 1-to-NUMOUT stream demultiplexer with valid/ready flow control and packet-locked routing; the transmit-side counterpart of the team's `mux` block. Each input word, tagged with `din_last`, is steered to one output lane. Each lane has a one-entry holding register, so a stalled lane back-pressures only the input while it is selected. Routing is locked for the duration of a packet, so multi-word packets never split across lanes.

---
 rtl/demux.sv | 124 ++++++++++++
 tb/tb_demux.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux.sv
// Registered 1-to-NUMOUT stream demultiplexer with per-lane one-entry holding
// registers and routing locked for the duration of a packet.
module demux #(
  parameter int NUMOUT = 16,
  parameter int SWIDTH = $clog2(NUMOUT),
  parameter int DWIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SWIDTH-1:0]        sel,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     din_v,
  input  logic                     din_last,
  output logic                     din_rdy,
  output logic [NUMOUT*DWIDTH-1:0] dout_vec,
  output logic [NUMOUT-1:0]        dout_vec_v,
  output logic [NUMOUT-1:0]        dout_vec_last,
  input  logic [NUMOUT-1:0]        dout_vec_rdy,
  output logic                     busy,
  output logic [SWIDTH-1:0]        cur_sel,
  output logic [15:0]              drop_cnt
);

  localparam int NPAD = 1 << SWIDTH;

  typedef enum logic {IDLE, PKT} state_t;

  state_t             state_reg, state_next;
  logic [SWIDTH-1:0]  cur_sel_reg, cur_sel_next;
  logic [15:0]        drop_cnt_reg;
  logic [SWIDTH-1:0]  esel;
  logic               in_range;
  logic               accept;
  logic [NUMOUT-1:0]  lane_v, lane_last;
  logic [NPAD-1:0]    v_pad, rdy_pad;

  assign esel     = (state_reg == PKT) ? cur_sel_reg : sel;
  assign in_range = ({{(32-SWIDTH){1'b0}}, esel} < 32'(NUMOUT));

  // Pad lane flags to the full select range so indexing by esel is always legal.
  genvar gi;
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_pad
      if (gi < NUMOUT) begin : g_real
        assign v_pad[gi]   = lane_v[gi];
        assign rdy_pad[gi] = dout_vec_rdy[gi];
      end else begin : g_none
        assign v_pad[gi]   = 1'b0;
        assign rdy_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign din_rdy = rst_n && (!in_range || !v_pad[esel] || rdy_pad[esel]);
  assign accept  = din_v && din_rdy;

  generate
    for (gi = 0; gi < NUMOUT; gi++) begin : g_lane
      logic              v_reg, last_reg, load;
      logic [DWIDTH-1:0] data_reg;

      assign load = accept && in_range && (esel == SWIDTH'(gi));

      // A load in the same cycle as a drain keeps the lane full.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg    <= 1'b0;
          last_reg <= 1'b0;
          data_reg <= '0;
        end else if (load) begin
          v_reg    <= 1'b1;
          last_reg <= din_last;
          data_reg <= din;
        end else if (v_reg && dout_vec_rdy[gi]) begin
          v_reg <= 1'b0;
        end
      end

      assign lane_v[gi]                       = v_reg;
      assign lane_last[gi]                    = last_reg;
      assign dout_vec[gi*DWIDTH +: DWIDTH]    = data_reg;
    end
  endgenerate

  assign dout_vec_v    = lane_v;
  assign dout_vec_last = lane_last;

  always_comb begin
    state_next   = state_reg;
    cur_sel_next = cur_sel_reg;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (!din_last) begin
            state_next   = PKT;
            cur_sel_next = sel;
          end
        end
        PKT: begin
          if (din_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cur_sel_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cur_sel_reg <= cur_sel_next;
      if (accept && !in_range && (drop_cnt_reg != 16'hFFFF))
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign busy     = (state_reg == PKT);
  assign cur_sel  = cur_sel_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed vector table, hand-written corner
// sequences, and randomized traffic against a per-lane queue scoreboard.
module tb_demux;
  localparam int N   = 16;
  localparam int N10 = 10;
  localparam int SW  = 4;
  localparam int DW  = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [SW-1:0]   sel, cur_sel;
  logic [DW-1:0]   din;
  logic            din_v, din_last, din_rdy, busy;
  logic [N*DW-1:0] dout_vec;
  logic [N-1:0]    dout_vec_v, dout_vec_last, dout_vec_rdy;
  logic [15:0]     drop_cnt;

  logic [SW-1:0]     sel10, cur_sel10;
  logic [DW-1:0]     din10;
  logic              din_v10, din_last10, din_rdy10, busy10;
  logic [N10*DW-1:0] dout10;
  logic [N10-1:0]    v10, last10, rdy10;
  logic [15:0]       drop10;

  demux #(.NUMOUT(N), .SWIDTH(SW), .DWIDTH(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .din(din), .din_v(din_v),
    .din_last(din_last), .din_rdy(din_rdy), .dout_vec(dout_vec),
    .dout_vec_v(dout_vec_v), .dout_vec_last(dout_vec_last),
    .dout_vec_rdy(dout_vec_rdy), .busy(busy), .cur_sel(cur_sel),
    .drop_cnt(drop_cnt)
  );

  demux #(.NUMOUT(N10), .SWIDTH(SW), .DWIDTH(DW)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .sel(sel10), .din(din10), .din_v(din_v10),
    .din_last(din_last10), .din_rdy(din_rdy10), .dout_vec(dout10),
    .dout_vec_v(v10), .dout_vec_last(last10), .dout_vec_rdy(rdy10),
    .busy(busy10), .cur_sel(cur_sel10), .drop_cnt(drop10)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane16(input int i);
    return dout_vec[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] lane10(input int i);
    return dout10[i*DW +: DW];
  endfunction

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] din;
    logic [N-1:0]  exp_v;
  } vec_t;
  vec_t tbl[N];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } word_t;
  word_t mq[N][$];

  initial begin
    int busy_cnt;
    logic m_in_pkt;
    logic [SW-1:0] m_lock;
    int esel_m;
    logic exp_rdy;
    logic [N-1:0] exp_vmask;

    for (int k = 0; k < N; k++) begin
      tbl[k].sel   = SW'(k);
      tbl[k].din   = DW'(k);
      tbl[k].exp_v = N'(1) << k;
    end

    // Reset with a word offered
    rst_n = 1'b0; din_v = 1'b1; sel = '0; din = '0; din_last = 1'b1; dout_vec_rdy = '1;
    sel10 = '0; din10 = '0; din_v10 = 1'b0; din_last10 = 1'b0; rdy10 = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_valid", dout_vec_v, 0);
    chk("rst_last", dout_vec_last, 0);
    chk("rst_data_any", |dout_vec, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_sel", cur_sel, 0);
    @(negedge clk);
    din_v = 1'b0; rst_n = 1'b1;
    #1;
    chk("rel_din_rdy", din_rdy, 1);
    $display("reset: released");

    // Single-word sweep
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      sel = tbl[k].sel; din = tbl[k].din; din_last = 1'b1; din_v = 1'b1;
      #1;
      chk("sweep_rdy", din_rdy, 1);
      @(negedge clk);
      din_v = 1'b0;
      #1;
      chk("sweep_onehot", dout_vec_v, tbl[k].exp_v);
      chk("sweep_data", lane16(k), tbl[k].din);
      chk("sweep_last", dout_vec_last[k], 1);
      chk("sweep_busy", busy, 0);
      $display("sweep: sel %0d data %h", k, tbl[k].din);
    end

    // Packet lock on lane 3, sel moves to 7 after first word
    busy_cnt = 0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        sel = (k == 0) ? 4'd3 : 4'd7;
        din = DW'(14'h100 + k); din_last = (k == 3); din_v = 1'b1;
      end else begin
        din_v = 1'b0;
      end
      #1;
      if (k > 0) begin
        chk("lock_v3", dout_vec_v[3], 1);
        chk("lock_data", lane16(3), 14'h100 + k - 1);
        chk("lock_v7", dout_vec_v[7], 0);
        $display("lock: lane 3 word %h", lane16(3));
      end
      busy_cnt += int'(busy);
    end
    chk("lock_busy_cycles", busy_cnt, 3);
    chk("lock_last", dout_vec_last[3], 1);

    // Backpressure on lane 5
    @(negedge clk);
    dout_vec_rdy = 16'hFFDF; sel = 4'd5; din = 14'h205; din_last = 1'b0; din_v = 1'b1;
    #1;
    chk("bp_rdy_first", din_rdy, 1);
    @(negedge clk);
    din = 14'h206; din_last = 1'b1; sel = 4'd0;
    #1;
    chk("bp_v5", dout_vec_v[5], 1);
    chk("bp_word1", lane16(5), 14'h205);
    chk("bp_rdy_blocked", din_rdy, 0);
    @(negedge clk);
    #1;
    chk("bp_hold_word", lane16(5), 14'h205);
    chk("bp_hold_last", dout_vec_last[5], 0);
    chk("bp_still_blocked", din_rdy, 0);
    @(negedge clk);
    dout_vec_rdy[5] = 1'b1;
    #1;
    chk("bp_rdy_open", din_rdy, 1);
    @(negedge clk);
    dout_vec_rdy[5] = 1'b0; din_v = 1'b0;
    #1;
    chk("bp_v5_nogap", dout_vec_v[5], 1);
    chk("bp_word2", lane16(5), 14'h206);
    chk("bp_last2", dout_vec_last[5], 1);
    chk("bp_busy", busy, 0);
    $display("backpressure: lane 5 word %h", lane16(5));
    @(negedge clk);
    sel = 4'd2; din = 14'h222; din_last = 1'b1; din_v = 1'b1;
    #1;
    chk("bp_lane2_rdy", din_rdy, 1);
    @(negedge clk);
    din_v = 1'b0;
    #1;
    chk("bp_both_valid", dout_vec_v, 16'h0024);
    chk("bp_lane2_data", lane16(2), 14'h222);
    chk("bp_lane5_kept", lane16(5), 14'h206);
    $display("backpressure: lane 2 word %h", lane16(2));
    @(negedge clk);
    dout_vec_rdy = '1;
    @(negedge clk);
    #1;
    chk("bp_drained", dout_vec_v, 0);

    // Full rate, 32 words on lane 0
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (k < 32) begin
        sel = 4'd0; din = DW'(14'h300 + k); din_last = (k == 31); din_v = 1'b1;
      end else begin
        din_v = 1'b0;
      end
      #1;
      if (k < 32) chk("full_rdy", din_rdy, 1);
      if (k > 0) begin
        chk("full_v0", dout_vec_v[0], 1);
        chk("full_data", lane16(0), 14'h300 + k - 1);
      end
    end
    $display("full rate: 32 words on lane 0");

    // Out-of-range select on the 10-lane instance
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        sel10 = 4'd12; din10 = DW'(k); din_last10 = (k == 2); din_v10 = 1'b1;
      end else begin
        din_v10 = 1'b0;
      end
      #1;
      if (k < 3) chk("oor_rdy", din_rdy10, 1);
      chk("oor_no_valid", v10, 0);
      if (k == 1) chk("oor_busy", busy10, 1);
    end
    chk("oor_drop_cnt", drop10, 3);
    chk("oor_busy_end", busy10, 0);
    $display("out of range: drop_cnt %0d", drop10);

    // Packet on lane 1, reset after word 2
    @(negedge clk);
    sel10 = 4'd1; din10 = 14'h011; din_last10 = 1'b0; din_v10 = 1'b1;
    #1;
    chk("mid_rdy", din_rdy10, 1);
    @(negedge clk);
    din10 = 14'h012;
    #1;
    chk("mid_word1", lane10(1), 14'h011);
    @(negedge clk);
    din_v10 = 1'b0;
    #1;
    chk("mid_v_before", v10, 10'h002);
    chk("mid_word2", lane10(1), 14'h012);
    chk("mid_busy_before", busy10, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_v_cleared", v10, 0);
    chk("mid_busy_cleared", busy10, 0);
    chk("mid_rdy_in_rst", din_rdy10, 0);
    @(negedge clk);
    rst_n = 1'b1; sel10 = 4'd4; din10 = 14'h3AB; din_last10 = 1'b0; din_v10 = 1'b1;
    #1;
    chk("post_rst_rdy", din_rdy10, 1);
    @(negedge clk);
    din10 = 14'h3AC; din_last10 = 1'b1; sel10 = 4'd1;
    #1;
    chk("post_rst_route", v10, 10'h010);
    chk("post_rst_data", lane10(4), 14'h3AB);
    chk("post_rst_cur_sel", cur_sel10, 4);
    chk("post_rst_busy", busy10, 1);
    @(negedge clk);
    din_v10 = 1'b0;
    #1;
    chk("post_rst_data2", lane10(4), 14'h3AC);
    chk("post_rst_busy_end", busy10, 0);
    $display("reset mid-packet: rerouted to lane %0d", cur_sel10);

    // Randomized traffic against per-lane queue scoreboard
    m_in_pkt = 1'b0;
    m_lock   = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      din_v        = ($urandom_range(0, 3) != 0);
      sel          = SW'($urandom);
      din          = DW'($urandom);
      din_last     = ($urandom_range(0, 2) == 0);
      dout_vec_rdy = N'($urandom | $urandom);
      #1;
      esel_m  = m_in_pkt ? int'(m_lock) : int'(sel);
      exp_rdy = (mq[esel_m].size() == 0) || dout_vec_rdy[esel_m];
      chk("rnd_din_rdy", din_rdy, exp_rdy);
      exp_vmask = '0;
      for (int i = 0; i < N; i++) exp_vmask[i] = (mq[i].size() != 0);
      chk("rnd_valid", dout_vec_v, exp_vmask);
      chk("rnd_busy", busy, m_in_pkt);
      if (m_in_pkt) chk("rnd_cur_sel", cur_sel, m_lock);
      for (int i = 0; i < N; i++) begin
        if (mq[i].size() != 0) begin
          chk("rnd_data", lane16(i), mq[i][0].d);
          chk("rnd_last", dout_vec_last[i], mq[i][0].l);
          if (dout_vec_rdy[i]) void'(mq[i].pop_front());
        end
      end
      if (din_v && exp_rdy) begin
        mq[esel_m].push_back('{d: din, l: din_last});
        $display("random: lane %0d data %h last %0b", esel_m, din, din_last);
        if (!m_in_pkt && !din_last) begin
          m_in_pkt = 1'b1;
          m_lock   = sel;
        end else if (m_in_pkt && din_last) begin
          m_in_pkt = 1'b0;
        end
      end
    end
    @(negedge clk);
    din_v = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
